// File: rtl/dmem_mmio_if.sv
// Data-side bus between the single-cycle core (master) and dmem_mmio (slave).
// Load data returns combinationally in the same cycle as the request.
interface dmem_mmio_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  modport master (
    output memread, memwrite, mem_addr, mem_writedata,
    input  mem_readdata
  );

  modport slave (
    input  memread, memwrite, mem_addr, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/dmem_mmio.sv
// Word RAM plus MMIO page (cycle counter, byte TX FIFO, GPIO) for the single-cycle core.
// Optional misaligned-access suppression and sticky flag: define ALIGN_CHECK_EN.
module dmem_mmio #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 3,
  parameter int          GPIO_W    = 8,
  parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  dmem_mmio_if.slave        bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              align_err
);

  localparam int               DEPTH      = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0]      OFF_CYCLE  = 16'h0000;
  localparam logic [15:0]      OFF_TX     = 16'h0004;
  localparam logic [15:0]      OFF_STATUS = 16'h0008;
  localparam logic [15:0]      OFF_GPIO   = 16'h000C;

  logic [31:0]        r_ram [2**RAM_AW];
  logic [7:0]         r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;
  logic [31:0]        r_cycle;
  logic [GPIO_W-1:0]  r_gpio;

  logic               w_misal, w_rd, w_wr, w_is_mmio;
  logic [15:0]        w_off;
  logic [RAM_AW-1:0]  w_idx;
  logic               w_full, w_empty, w_push_req, w_push, w_pop, w_stat_rd;
  logic [31:0]        w_status, w_gpio_rd;

`ifdef ALIGN_CHECK_EN
  logic r_align_err;
  assign w_misal = |bus.mem_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset)
      r_align_err <= 1'b0;
    else if ((bus.memread || bus.memwrite) && w_misal)
      r_align_err <= 1'b1;
  end
  assign align_err = r_align_err;
`else
  assign w_misal   = 1'b0;
  assign align_err = 1'b0;
`endif

  assign w_rd      = bus.memread  && !w_misal;
  assign w_wr      = bus.memwrite && !w_misal;
  assign w_is_mmio = (bus.mem_addr[31:16] == MMIO_PAGE);
  assign w_off     = bus.mem_addr[15:0];
  assign w_idx     = bus.mem_addr[RAM_AW+1:2];

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_wr && w_is_mmio && (w_off == OFF_TX);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = tx_valid && tx_ready;
  assign w_stat_rd  = w_rd && w_is_mmio && (w_off == OFF_STATUS);

  // Store in the reset cycle is dropped, matching the register side.
  always_ff @(posedge clk) begin
    if (!reset && w_wr && !w_is_mmio)
      r_ram[w_idx] <= bus.mem_writedata;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_fifo[r_wptr] <= bus.mem_writedata[7:0];
  end

  // Fullness is judged on the pre-edge count, so a pop cannot make room for a same-edge push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full)
        r_ovf <= 1'b1;
      else if (w_stat_rd)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
      r_gpio  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr && w_is_mmio && (w_off == OFF_GPIO))
        r_gpio <= bus.mem_writedata[GPIO_W-1:0];
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[0]             = w_full;
    w_status[1]             = w_empty;
    w_status[2]             = r_ovf;
    w_status[3+FIFO_AW:3]   = r_count;
    w_gpio_rd               = '0;
    w_gpio_rd[GPIO_W-1:0]   = r_gpio;
  end

  always_comb begin
    bus.mem_readdata = '0;
    if (w_rd) begin
      if (w_is_mmio) begin
        case (w_off)
          OFF_CYCLE:  bus.mem_readdata = r_cycle;
          OFF_STATUS: bus.mem_readdata = w_status;
          OFF_GPIO:   bus.mem_readdata = w_gpio_rd;
          default:    bus.mem_readdata = '0;
        endcase
      end else begin
        bus.mem_readdata = r_ram[w_idx];
      end
    end
  end

  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign gpio_out = r_gpio;

endmodule
